// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding, point values and score limit for the game sequencer
`timescale 1ns/1ps
package game_pkg;

  typedef enum logic [3:0] {
    ST_START = 4'd0,
    ST_PLAY  = 4'd1,
    ST_WIN   = 4'd2,
    ST_OVER  = 4'd3
  } game_state_t;

  // Points per kill, counted in tens (the units digit is never touched).
  localparam logic [1:0] PTS_TOP = 2'd3;
  localparam logic [1:0] PTS_MID = 2'd2;
  localparam logic [1:0] PTS_LOW = 2'd1;

  localparam logic [15:0] SCORE_MAX = 16'h9999;

  // Rows 0-1 are the top invaders, 4-5 the bottom ones; 6-7 are not real rows.
  function automatic logic [1:0] row_points(input logic [2:0] row);
    logic [1:0] pts;
    case (row)
      3'd0, 3'd1: pts = PTS_TOP;
      3'd2, 3'd3: pts = PTS_MID;
      3'd4, 3'd5: pts = PTS_LOW;
      default:    pts = 2'd0;
    endcase
    return pts;
  endfunction

endpackage

// File: rtl/bcd_score_accum.sv
// rtl/bcd_score_accum.sv - four-digit BCD score register with tens-digit add and 9999 saturation
`timescale 1ns/1ps
module bcd_score_accum
  import game_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        clear,
  input  logic        add_en,
  input  logic [1:0]  tens_in,
  output logic [15:0] score_bcd
);

  logic [15:0] r_score;
  logic [4:0]  w_t_sum;
  logic [4:0]  w_h_sum;
  logic [4:0]  w_k_sum;
  logic        w_t_c;
  logic        w_h_c;
  logic        w_k_ovf;
  logic [3:0]  w_t_dig;
  logic [3:0]  w_h_dig;
  logic [15:0] w_next;

  // Ripple the tens addition through hundreds and thousands; a thousands overflow pins the score.
  always_comb begin
    w_t_sum = {1'b0, r_score[7:4]} + {3'b000, tens_in};
    w_t_c   = (w_t_sum > 5'd9);
    w_t_dig = w_t_c ? 4'(w_t_sum - 5'd10) : w_t_sum[3:0];
    w_h_sum = {1'b0, r_score[11:8]} + {4'b0000, w_t_c};
    w_h_c   = (w_h_sum > 5'd9);
    w_h_dig = w_h_c ? 4'd0 : w_h_sum[3:0];
    w_k_sum = {1'b0, r_score[15:12]} + {4'b0000, w_h_c};
    w_k_ovf = (w_k_sum > 5'd9);
    if (w_k_ovf) begin
      w_next = SCORE_MAX;
    end else begin
      w_next = {w_k_sum[3:0], w_h_dig, w_t_dig, r_score[3:0]};
    end
  end

  // Clear has priority; otherwise accumulate when a kill is reported.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_score <= 16'h0000;
    end else if (clear) begin
      r_score <= 16'h0000;
    end else if (add_en) begin
      r_score <= w_next;
    end
  end

  assign score_bcd = r_score;

endmodule

// File: rtl/game_flow_controller.sv
// rtl/game_flow_controller.sv - start/play/win/over sequencer with lives, invincibility blink and scoring
`timescale 1ns/1ps
module game_flow_controller
  import game_pkg::*;
#(
  parameter int START_LIVES    = 3,
  parameter int INVULN_FRAMES  = 120,
  parameter int FLASH_HALF     = 8,
  parameter int HOLDOFF_FRAMES = 60
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_tick,
  input  logic        key_space,
  input  logic        player_hit,
  input  logic        enemy_killed,
  input  logic [2:0]  kill_row,
  input  logic        wave_cleared,
  input  logic        enemies_landed,
  output logic [3:0]  state,
  output logic [2:0]  player_lives,
  output logic        player_unkillable,
  output logic        player_flash,
  output logic [15:0] score_bcd,
  output logic        new_game,
  output logic        new_wave
);

  localparam int INV_W = $clog2(INVULN_FRAMES + 1);
  localparam int PH_W  = $clog2(FLASH_HALF + 1);
  localparam int HO_W  = $clog2(HOLDOFF_FRAMES + 1);

  localparam logic [2:0]       LIVES_INIT = 3'(START_LIVES);
  localparam logic [INV_W-1:0] INV_LOAD   = INV_W'(INVULN_FRAMES);
  localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(FLASH_HALF - 1);
  localparam logic [HO_W-1:0]  HOLD_LOAD  = HO_W'(HOLDOFF_FRAMES);

  game_state_t       r_state;
  logic [2:0]        r_lives;
  logic              r_unk;
  logic              r_flash;
  logic              r_new_game;
  logic              r_new_wave;
  logic [INV_W-1:0]  r_inv_cnt;
  logic [PH_W-1:0]   r_phase;
  logic [HO_W-1:0]   r_hold;
  logic              r_space_d;

  logic              w_press;
  logic              w_hit;
  logic              w_fatal;
  logic              w_score_clear;
  logic              w_score_add;
  logic [1:0]        w_points;
  logic [15:0]       w_score;

  assign w_press       = key_space & ~r_space_d;
  assign w_hit         = player_hit & ~r_unk;
  assign w_fatal       = w_hit & (r_lives <= 3'd1);
  assign w_score_clear = (r_state == ST_START) & w_press;
  assign w_score_add   = (r_state == ST_PLAY) & enemy_killed;
  assign w_points      = row_points(kill_row);

  bcd_score_accum u_score (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .clear     (w_score_clear),
    .add_en    (w_score_add),
    .tens_in   (w_points),
    .score_bcd (w_score)
  );

  // Game sequencer: state, lives, invincibility/blink, holdoff and one-cycle pulses.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= ST_START;
      r_lives    <= LIVES_INIT;
      r_unk      <= 1'b0;
      r_flash    <= 1'b0;
      r_new_game <= 1'b0;
      r_new_wave <= 1'b0;
      r_inv_cnt  <= '0;
      r_phase    <= '0;
      r_hold     <= '0;
      r_space_d  <= 1'b0;
    end else begin
      r_space_d  <= key_space;
      r_new_game <= 1'b0;
      r_new_wave <= 1'b0;
      case (r_state)
        ST_START: begin
          if (w_press) begin
            r_state    <= ST_PLAY;
            r_lives    <= LIVES_INIT;
            r_unk      <= 1'b0;
            r_flash    <= 1'b0;
            r_inv_cnt  <= '0;
            r_phase    <= '0;
            r_new_game <= 1'b1;
          end
        end
        ST_PLAY: begin
          // Invincibility countdown; the last tick drops both unkillable and the blink.
          if (r_unk && frame_tick) begin
            if (r_inv_cnt == INV_W'(1)) begin
              r_unk     <= 1'b0;
              r_flash   <= 1'b0;
              r_inv_cnt <= '0;
              r_phase   <= '0;
            end else begin
              r_inv_cnt <= r_inv_cnt - INV_W'(1);
              if (r_phase == PH_LAST) begin
                r_phase <= '0;
                r_flash <= ~r_flash;
              end else begin
                r_phase <= r_phase + PH_W'(1);
              end
            end
          end
          if (enemies_landed || w_fatal) begin
            r_state   <= ST_OVER;
            r_lives   <= 3'd0;
            r_hold    <= HOLD_LOAD;
            r_unk     <= 1'b0;
            r_flash   <= 1'b0;
            r_inv_cnt <= '0;
            r_phase   <= '0;
          end else begin
            if (w_hit) begin
              r_lives   <= r_lives - 3'd1;
              r_inv_cnt <= INV_LOAD;
              r_unk     <= 1'b1;
              r_phase   <= '0;
              r_flash   <= 1'b1;
            end
            // Entering WIN overrides any invincibility the same-cycle hit just started.
            if (wave_cleared) begin
              r_state   <= ST_WIN;
              r_hold    <= HOLD_LOAD;
              r_unk     <= 1'b0;
              r_flash   <= 1'b0;
              r_inv_cnt <= '0;
              r_phase   <= '0;
            end
          end
        end
        ST_WIN: begin
          if (w_press && (r_hold == '0)) begin
            r_state    <= ST_PLAY;
            r_new_wave <= 1'b1;
          end else if (frame_tick && (r_hold != '0)) begin
            r_hold <= r_hold - HO_W'(1);
          end
        end
        ST_OVER: begin
          if (w_press && (r_hold == '0)) begin
            r_state <= ST_START;
          end else if (frame_tick && (r_hold != '0)) begin
            r_hold <= r_hold - HO_W'(1);
          end
        end
        default: begin
          r_state <= ST_START;
        end
      endcase
    end
  end

  a_start_lives_range: assert property (@(posedge Clk) (START_LIVES >= 1) && (START_LIVES <= 7));

  assign state             = r_state;
  assign player_lives      = r_lives;
  assign player_unkillable = r_unk;
  assign player_flash      = r_flash;
  assign score_bcd         = w_score;
  assign new_game          = r_new_game;
  assign new_wave          = r_new_wave;

endmodule
